mio_bus_pipelined: RTL
======================

# mio_bus_pipelined

Parametrised, registered memory-mapped I/O bus controller between the CPU data port and up to NUM_SLV slaves (data RAM, VRAM, PS/2, seven-segment GPIO, LED/counter GPIO). Base/mask address decoding and per-slot wait states are set by parameters. Each access runs as a request/ready transaction, so slow slaves can be added without touching the CPU. Unmapped accesses are reported through a sticky error register.

## Interface
Parameters:
- NUM_SLV, 5, number of slave slots (1..8)
- SLV_BASE, {32'hFFFFFF00, 32'hFFFFFE00, 32'hFFFFD000, 32'h000C0000, 32'h00000000}, packed NUM_SLV×32 base addresses; slot i occupies bits [32i+31:32i]
- SLV_MASK, {32'hFFFFFF00, 32'hFFFFFF00, 32'hFFFFF000, 32'hFFFF0000, 32'hFFFF0000}, packed NUM_SLV×32 compare masks
- SLV_WAIT, {4'd0, 4'd0, 4'd1, 4'd0, 4'd0}, packed NUM_SLV×4 extra wait cycles per slot (0..15)

Ports:
- clk  in  1  system clock; everything is on the rising edge
- rst  in  1  asynchronous, active-high reset
- cpu_req  in  1  request; held high until cpu_ready
- cpu_we  in  1  1 = write, 0 = read
- addr_bus  in  32  byte address
- Cpu_data2bus  in  32  write data
- Cpu_data4bus  out  32  read data, valid when cpu_ready = 1
- cpu_ready  out  1  one-cycle transaction-complete pulse
- slv_sel  out  NUM_SLV  one-hot select, high for the whole access phase
- slv_we  out  NUM_SLV  one-cycle write strobe
- slv_rd  out  NUM_SLV  one-cycle read strobe (PS/2 pop)
- slv_addr  out  32  latched address
- slv_wdata  out  32  latched write data
- slv_rdata  in  NUM_SLV×32  packed slave read data
- err_clr  in  1  clears bus_err
- bus_err  out  1  sticky flag: an unmapped access occurred
- err_addr  out  32  address of the first unmapped access since the last clear

## Operation
- Decode: slot i hits when (addr_bus & MASK_i) == (BASE_i & MASK_i). If several slots hit, the lowest index wins. If none hits, the access is unmapped.
- State machine has three states: IDLE, ACCESS, RESP.
- IDLE: cpu_req is sampled here only. On a hit, latch addr, wdata, we, slot index and wait count, then go to ACCESS. On a miss, go to RESP with read data 0 and set bus_err; err_addr is captured only if bus_err was 0.
- ACCESS: slv_sel[slot] = 1. On the first cycle only, pulse slv_we[slot] (write) or slv_rd[slot] (read). The counter starts at SLV_WAIT[slot] and decrements each cycle. When the counter reaches 0, register slv_rdata[slot] into the read-data register (forced to 0 for writes) and go to RESP.
- RESP: cpu_ready = 1 and Cpu_data4bus holds the registered data. Next state is always IDLE.
- Cpu_data4bus holds its value until the next RESP.
- err_clr: clears bus_err and err_addr in the next cycle. If err_clr coincides with a new miss, set wins and err_addr takes the new address.
- cpu_req dropped mid-transaction: no effect; the transaction completes.

## Timing
- Request sampled in cycle T, ACCESS from T+1, cpu_ready at T+2+W (W = slot wait). Unmapped access: cpu_ready at T+1.
- Throughput is one transaction per 3+W cycles. The next request is sampled the cycle after cpu_ready. A cpu_req still high in the RESP cycle is not a new request.
- Exactly one slv_we or slv_rd pulse per mapped transaction, never on unmapped accesses.
- Reset values: state IDLE, and every output is 0 (slv_*, cpu_ready, Cpu_data4bus, bus_err, err_addr).
- Reset mid-transaction aborts immediately: no strobe and no cpu_ready are issued afterwards.

## Test plan
- Read 0x00000010 (slot 0, W=0), slv_rdata slot 0 = 0x12345678 → slv_rd[0] pulse at T+1, cpu_ready at T+2, Cpu_data4bus = 0x12345678.
- Write 0x000C0104 with data 0x000007FF → slv_we[1] single pulse at T+1, slv_addr = 0x000C0104, slv_wdata = 0x7FF, cpu_ready at T+2.
- Read 0xFFFFD000 (PS/2, W=1) → slv_rd[2] exactly one pulse, slv_sel[2] high for 2 cycles, cpu_ready at T+3.
- Read 0x80000000 (unmapped) → no strobes, cpu_ready at T+1 with data 0, bus_err = 1, err_addr = 0x80000000. A second miss at 0x90000000 leaves err_addr unchanged. err_clr then clears both.
- Overlap: set SLV_BASE[1] = 0 with mask 0xFFFF0000 → access 0x00000020 selects slot 0 only.
- Assert rst during the ACCESS wait cycle of a PS/2 read → all outputs 0 asynchronously. No cpu_ready follows, and the next request completes normally.

Source files
------------

// File: rtl/mio_bus_pipelined_if.sv
// mio_bus_pipelined_if: CPU data port and slave-side bus signals of the MMIO controller
interface mio_bus_pipelined_if #(
  parameter int NUM_SLV = 5
);
  logic                   cpu_req;
  logic                   cpu_we;
  logic [31:0]            addr_bus;
  logic [31:0]            Cpu_data2bus;
  logic [31:0]            Cpu_data4bus;
  logic                   cpu_ready;
  logic [NUM_SLV-1:0]     slv_sel;
  logic [NUM_SLV-1:0]     slv_we;
  logic [NUM_SLV-1:0]     slv_rd;
  logic [31:0]            slv_addr;
  logic [31:0]            slv_wdata;
  logic [NUM_SLV*32-1:0]  slv_rdata;
  logic                   err_clr;
  logic                   bus_err;
  logic [31:0]            err_addr;
  modport master (
    output cpu_req, cpu_we, addr_bus, Cpu_data2bus, slv_rdata, err_clr,
    input  Cpu_data4bus, cpu_ready, slv_sel, slv_we, slv_rd, slv_addr, slv_wdata, bus_err, err_addr
  );
  modport slave (
    input  cpu_req, cpu_we, addr_bus, Cpu_data2bus, slv_rdata, err_clr,
    output Cpu_data4bus, cpu_ready, slv_sel, slv_we, slv_rd, slv_addr, slv_wdata, bus_err, err_addr
  );
endinterface

// File: rtl/mio_bus_pipelined.sv
// mio_bus_pipelined: registered base/mask MMIO decoder with per-slot wait states and sticky unmapped-access error
module mio_bus_pipelined #(
  parameter int                    NUM_SLV  = 5,
  parameter logic [NUM_SLV*32-1:0] SLV_BASE = {32'hFFFFFF00, 32'hFFFFFE00, 32'hFFFFD000, 32'h000C0000, 32'h00000000},
  parameter logic [NUM_SLV*32-1:0] SLV_MASK = {32'hFFFFFF00, 32'hFFFFFF00, 32'hFFFFF000, 32'hFFFF0000, 32'hFFFF0000},
  parameter logic [NUM_SLV*4-1:0]  SLV_WAIT = {4'd0, 4'd0, 4'd1, 4'd0, 4'd0}
) (
  input logic               clk,
  input logic               rst,
  mio_bus_pipelined_if.slave bus
);
  localparam int IW = NUM_SLV > 1 ? $clog2(NUM_SLV) : 1;
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t          state_q, state_d;
  logic [IW-1:0]   slot_q, slot_d, hit_idx;
  logic            hit;
  logic [3:0]      cnt_q, cnt_d;
  logic            we_q, we_d, first_q, first_d, err_q, err_d;
  logic [31:0]     addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d, eaddr_q, eaddr_d;
  // Scan from the top slot down so the lowest matching index is the one left standing
  always_comb begin
    hit = 1'b0;
    hit_idx = '0;
    for (int i = NUM_SLV - 1; i >= 0; i--)
      if ((bus.addr_bus & SLV_MASK[32*i +: 32]) == (SLV_BASE[32*i +: 32] & SLV_MASK[32*i +: 32])) begin
        hit = 1'b1;
        hit_idx = IW'(i);
      end
  end
  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    first_d = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    eaddr_d = eaddr_q;
    if (bus.err_clr) begin
      err_d   = 1'b0;
      eaddr_d = '0;
    end
    case (state_q)
      IDLE: if (bus.cpu_req) begin
        if (hit) begin
          state_d = ACCESS;
          slot_d  = hit_idx;
          cnt_d   = SLV_WAIT[4*int'(hit_idx) +: 4];
          we_d    = bus.cpu_we;
          first_d = 1'b1;
          addr_d  = bus.addr_bus;
          wdata_d = bus.Cpu_data2bus;
        end else begin
          state_d = RESP;
          rdata_d = '0;
          err_d   = 1'b1;
          eaddr_d = (!err_q || bus.err_clr) ? bus.addr_bus : eaddr_q;
        end
      end
      ACCESS: if (cnt_q == 4'd0) begin
        state_d = RESP;
        rdata_d = we_q ? '0 : bus.slv_rdata[32*int'(slot_q) +: 32];
      end else cnt_d = cnt_q - 4'd1;
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      slot_q  <= '0;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      first_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      eaddr_q <= '0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      first_q <= first_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      eaddr_q <= eaddr_d;
    end
  // first_q is only ever set on entry to ACCESS, so strobes fire once per mapped access
  assign bus.slv_sel      = (state_q == ACCESS) ? NUM_SLV'(1) << slot_q : '0;
  assign bus.slv_we       = (first_q && we_q) ? bus.slv_sel : '0;
  assign bus.slv_rd       = (first_q && !we_q) ? bus.slv_sel : '0;
  assign bus.cpu_ready    = state_q == RESP;
  assign bus.Cpu_data4bus = rdata_q;
  assign bus.slv_addr     = addr_q;
  assign bus.slv_wdata    = wdata_q;
  assign bus.bus_err      = err_q;
  assign bus.err_addr     = eaddr_q;
endmodule
